led_blink_sched: RTL and testbench

- Shared-prescaler scheduler for the board's LED blink channels. It replaces the free-running per-LED dividers with one prescaler and one programmable period counter per channel.
- Software or a test harness programs each channel's period and enable over a valid/ready config port.
- Outputs are glitch-free LED levels and single-cycle tick strobes, used by the top-level LED wrapper and by the processor status logic.

---
 rtl/led_sched_pkg.sv | 9 +
 rtl/led_blink_sched_if.sv | 18 +
 rtl/led_sched_chan.sv | 84 ++++++++
 rtl/led_blink_sched.sv | 82 ++++++++
 tb/tb_led_blink_sched.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/led_sched_pkg.sv
// led_sched_pkg: shared types and constants for the LED blink scheduler
package led_sched_pkg;
    typedef enum logic {IDLE, APPLY} cfg_state_t;
    localparam int PRESCALE_DEF = 50000;
    localparam int CNT_W_DEF = 16;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/led_blink_sched_if.sv
// led_blink_sched_if: config port and LED outputs of the blink scheduler
interface led_blink_sched_if
    import led_sched_pkg::*;
#(
    parameter int NCH = 2,
    parameter int CNT_W = CNT_W_DEF
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [ch_w(NCH)-1:0]   cfg_ch;
    logic [CNT_W-1:0]       cfg_period;
    logic                   cfg_enable;
    logic [NCH-1:0]         led_out;
    logic [NCH-1:0]         tick;
    logic                   busy;
    modport master (output cfg_valid, cfg_ch, cfg_period, cfg_enable, input cfg_ready, led_out, tick, busy);
    modport slave (input cfg_valid, cfg_ch, cfg_period, cfg_enable, output cfg_ready, led_out, tick, busy);
endinterface

// File: rtl/led_sched_chan.sv
// led_sched_chan: one blink channel with glitch-free shadowed period update (align port with LED_PHASE_ALIGN_EN)
module led_sched_chan
    import led_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_base_tick,
    input  logic             i_commit,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_period,
`ifdef LED_PHASE_ALIGN_EN
    input  logic             i_align,
`endif
    output logic             o_led,
    output logic             o_tick,
    output logic             o_en
);
    logic [CNT_W-1:0] r_cnt, r_active, r_shadow;
    logic             r_pend, r_en, r_led, r_tick;
    logic             w_run, w_wrap;
    logic [CNT_W-1:0] w_next_active;

    assign w_run = r_en && (r_active != '0);
    assign w_wrap = w_run && i_base_tick && (r_cnt == r_active - CNT_W'(1));
    assign w_next_active = r_pend ? r_shadow : r_active;

    // counter, wrap/toggle and commit; a commit overrides the same-edge wrap's period choice
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_active <= '0;
            r_shadow <= '0;
            r_pend <= 1'b0;
            r_en <= 1'b0;
            r_led <= 1'b0;
            r_tick <= 1'b0;
`ifdef LED_PHASE_ALIGN_EN
        end else if (i_align) begin
            r_cnt <= '0;
            r_led <= 1'b0;
            r_tick <= 1'b0;
`endif
        end else begin
            r_tick <= 1'b0;
            if (w_wrap) begin
                r_cnt <= '0;
                r_led <= ~r_led & (w_next_active != '0);
                r_tick <= 1'b1;
                r_active <= w_next_active;
                r_pend <= 1'b0;
            end else if (w_run && i_base_tick) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (i_commit) begin
                if (!i_enable) begin
                    r_en <= 1'b0;
                    r_cnt <= '0;
                    r_led <= 1'b0;
                    r_tick <= 1'b0;
                    r_pend <= 1'b0;
                end else if (!w_run) begin
                    r_en <= 1'b1;
                    r_active <= i_period;
                    r_cnt <= '0;
                    r_led <= 1'b0;
                    r_tick <= 1'b0;
                    r_pend <= 1'b0;
                end else if (w_wrap) begin
                    r_active <= i_period;
                    r_pend <= 1'b0;
                end else begin
                    r_shadow <= i_period;
                    r_pend <= 1'b1;
                end
            end
        end
    end

    assign o_led = r_led;
    assign o_tick = r_tick;
    assign o_en = r_en;
endmodule

// File: rtl/led_blink_sched.sv
// led_blink_sched: shared-prescaler LED blink scheduler; LED_PHASE_ALIGN_EN adds the align input
module led_blink_sched
    import led_sched_pkg::*;
#(
    parameter int NCH = 2,
    parameter int CNT_W = CNT_W_DEF,
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic clk,
    input  logic rst,
`ifdef LED_PHASE_ALIGN_EN
    input  logic align,
`endif
    led_blink_sched_if.slave bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam int CH_W = ch_w(NCH);

    logic [PW-1:0]    r_pre;
    cfg_state_t       r_state;
    logic             r_ready, r_enable;
    logic [CH_W-1:0]  r_ch;
    logic [CNT_W-1:0] r_period;
    logic             w_base_tick, w_align, w_commit;
    logic [NCH-1:0]   w_en;

`ifdef LED_PHASE_ALIGN_EN
    assign w_align = align;
`else
    assign w_align = 1'b0;
`endif
    assign w_base_tick = (r_pre == PW'(PRESCALE - 1));
    assign w_commit = (r_state == APPLY) && !w_align;

    // shared prescaler producing the base tick
    always_ff @(posedge clk) begin
        if (rst || w_align || w_base_tick) r_pre <= '0;
        else r_pre <= r_pre + PW'(1);
    end

    // config handshake: capture in IDLE, commit at the end of APPLY (held over an align cycle)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_ch <= '0;
            r_period <= '0;
            r_enable <= 1'b0;
        end else if (r_state == IDLE) begin
            if (bus.cfg_valid) begin
                r_ch <= bus.cfg_ch;
                r_period <= bus.cfg_period;
                r_enable <= bus.cfg_enable;
                r_state <= APPLY;
                r_ready <= 1'b0;
            end
        end else if (!w_align) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        led_sched_chan #(.CNT_W(CNT_W)) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_base_tick (w_base_tick),
            .i_commit    (w_commit && (r_ch == CH_W'(g))),
            .i_enable    (r_enable),
            .i_period    (r_period),
`ifdef LED_PHASE_ALIGN_EN
            .i_align     (w_align),
`endif
            .o_led       (bus.led_out[g]),
            .o_tick      (bus.tick[g]),
            .o_en        (w_en[g])
        );
    end

    assign bus.cfg_ready = r_ready;
    assign bus.busy = |w_en;
endmodule

// File: tb/tb_led_blink_sched.sv
// tb_led_blink_sched: scoreboard bench with a base-tick schedule reference model
module tb_led_blink_sched;
    import led_sched_pkg::*;
    localparam int NCH = 3;
    localparam int CNT_W = 8;
    localparam int PS = 4;
    localparam int CH_W = ch_w(NCH);
    localparam int VW = 2 * NCH + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic align = 1'b0;
    int errors = 0;
    int checks = 0;

    led_blink_sched_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    led_blink_sched #(.NCH(NCH), .CNT_W(CNT_W), .PRESCALE(PS)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef LED_PHASE_ALIGN_EN
        .align (align),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] exp_q[$];

    // reference model: each running channel holds the absolute base-tick index of its next toggle
    int m_pre, nb, nbn, m_ch, m_per;
    bit m_rdy, m_apply, m_enc, bt, al, commit;
    int m_act[NCH], m_sh[NCH], m_nxt[NCH];
    bit m_pend[NCH], run0[NCH], wrapped[NCH];
    logic [NCH-1:0] m_en, m_led, m_tick;

    always @(posedge clk) begin
        if (rst) begin
            m_pre = 0; nb = 0; m_rdy = 1; m_apply = 0;
            m_en = '0; m_led = '0; m_tick = '0;
            for (int c = 0; c < NCH; c++) begin
                m_act[c] = 0; m_sh[c] = 0; m_nxt[c] = 0; m_pend[c] = 0;
            end
        end else begin
            bt = (m_pre == PS - 1);
`ifdef LED_PHASE_ALIGN_EN
            al = align;
`else
            al = 0;
`endif
            m_pre = (al || bt) ? 0 : m_pre + 1;
            nbn = nb + ((bt && !al) ? 1 : 0);
            commit = m_apply && !al;
            m_tick = '0;
            for (int c = 0; c < NCH; c++) begin
                run0[c] = m_en[c] && m_act[c] != 0;
                wrapped[c] = 0;
                if (al) begin
                    m_led[c] = 0;
                    m_nxt[c] = nbn + m_act[c];
                end else if (run0[c] && bt && nbn == m_nxt[c]) begin
                    wrapped[c] = 1;
                    m_tick[c] = 1;
                    if (m_pend[c]) begin m_act[c] = m_sh[c]; m_pend[c] = 0; end
                    m_led[c] = (m_act[c] == 0) ? 1'b0 : ~m_led[c];
                    m_nxt[c] = nbn + m_act[c];
                end
            end
            if (commit && m_ch < NCH) begin
                if (!m_enc) begin
                    m_en[m_ch] = 0; m_led[m_ch] = 0; m_tick[m_ch] = 0; m_pend[m_ch] = 0;
                end else if (!run0[m_ch]) begin
                    m_en[m_ch] = 1; m_act[m_ch] = m_per; m_pend[m_ch] = 0;
                    m_led[m_ch] = 0; m_tick[m_ch] = 0; m_nxt[m_ch] = nbn + m_per;
                end else if (wrapped[m_ch]) begin
                    m_act[m_ch] = m_per; m_pend[m_ch] = 0; m_nxt[m_ch] = nbn + m_per;
                end else begin
                    m_sh[m_ch] = m_per; m_pend[m_ch] = 1;
                end
            end
            if (m_apply) begin
                if (!al) begin m_apply = 0; m_rdy = 1; end
            end else if (bus.cfg_valid) begin
                m_ch = int'(bus.cfg_ch); m_per = int'(bus.cfg_period); m_enc = bus.cfg_enable;
                m_apply = 1; m_rdy = 0;
            end
            nb = nbn;
        end
        exp_q.push_back({m_rdy, |m_en, m_tick, m_led});
    end

    // monitor: compare the DUT outputs presented each cycle with the oldest expectation
    logic [VW-1:0] got, exp_v;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got = {bus.cfg_ready, bus.busy, bus.tick, bus.led_out};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL outputs t=%0t got rdy=%b busy=%b tick=%b led=%b exp rdy=%b busy=%b tick=%b led=%b",
                         $time, got[VW-1], got[VW-2], got[2*NCH-1:NCH], got[NCH-1:0],
                         exp_v[VW-1], exp_v[VW-2], exp_v[2*NCH-1:NCH], exp_v[NCH-1:0]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int ch, input int per, input bit en);
        int guard = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_ch = ch[CH_W-1:0];
        bus.cfg_period = per[CNT_W-1:0];
        bus.cfg_enable = en;
        while (!bus.cfg_ready && guard < 10) begin
            step(1);
            guard++;
        end
        checks++;
        if (!bus.cfg_ready) begin
            errors++;
            $display("FAIL handshake timeout got cfg_ready=%b exp 1", bus.cfg_ready);
        end
        step(1);
    endtask

    task automatic cfg_idle();
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        int r;
        bus.cfg_valid = 1'b0;
        bus.cfg_ch = '0;
        bus.cfg_period = '0;
        bus.cfg_enable = 1'b0;
        step(3);
        rst = 1'b0;
        step(2);
        wr(0, 3, 1); cfg_idle(); step(30);
        wr(0, 1, 1); cfg_idle(); step(30);
        wr(1, 2, 1); cfg_idle(); step(20);
        wr(1, 2, 0); cfg_idle(); step(10);
        wr(1, 0, 1); cfg_idle(); step(10);
        wr(2, 2, 1); wr(1, 3, 1); cfg_idle(); step(3);
        wr(3, 5, 1); cfg_idle(); step(20);
`ifdef LED_PHASE_ALIGN_EN
        wr(0, 2, 1); cfg_idle(); step(5);
        wr(1, 2, 1); cfg_idle(); step(3);
        align = 1'b1; step(1); align = 1'b0; step(30);
`endif
        repeat (300) begin
            step($urandom_range(0, 12));
            r = $urandom_range(0, 99);
            if (r < 2) begin
                rst = 1'b1; step(1); rst = 1'b0;
`ifdef LED_PHASE_ALIGN_EN
            end else if (r < 8) begin
                align = 1'b1; step(1); align = 1'b0;
`endif
            end else begin
                wr($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4) != 0);
                if ($urandom_range(0, 1) != 0) cfg_idle();
            end
        end
        cfg_idle();
        step(40);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
